if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage; sits directly upstream of the decode stage and supplies its `inst` / `inst_ready` inputs, plus the instruction's PC.
Holds the architectural fetch PC and issues one 32-bit fetch at a time over a valid/ready request/response bus to instruction memory.
Holds a fetched instruction until decode accepts it. Accepts redirects (taken branch, jal, jalr) from execute and discards stale responses.
Non-pipelined: at most one request outstanding.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, fetch address after reset
INST_NOP, 32'h0000_0013, value driven on `inst` when not valid (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req_valid  out  1  fetch request valid
if_req_ready  in  1  memory accepts request
if_req_addr  out  64  fetch address, 4-byte aligned
if_rsp_valid  in  1  fetch data valid
if_rsp_ready  out  1  stage accepts response
if_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  execute redirect (single-cycle pulse)
redirect_pc  in  64  redirect target
id_ready  in  1  decode consumes the presented instruction this cycle
inst  out  32  instruction to decode
inst_ready  out  1  `inst` / `pc` valid
pc  out  64  PC of `inst`

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst` is synchronous and active-high.
  - The memory slave shares `rst`, so no response survives reset.
- Registers:
  - `fetch_pc` (next address to fetch).
  - `req_addr` (address of the in-flight request).
  - `discard` flag.
  - `inst`, `pc`.
  - 2-bit state: IDLE, REQ, WAIT, HOLD.
- Reset values:
  - state = IDLE, `fetch_pc` = PC_RESET, `req_addr` = PC_RESET, `discard` = 0.
  - `if_req_valid` = 0, `if_rsp_ready` = 0, `inst_ready` = 0.
  - `inst` = INST_NOP, `pc` = 0.
- All outputs are registers or decoded from state only; no combinational input-to-output path.
- IDLE: go to REQ next cycle and load `req_addr` <= `fetch_pc`.
- REQ:
  - `if_req_valid` = 1, `if_req_addr` = `req_addr`. The address and valid stay stable until `if_req_ready` = 1.
  - When `if_req_ready` = 1: go to WAIT.
- WAIT:
  - `if_rsp_ready` = 1.
  - On `if_rsp_valid` with `discard` = 0 and no redirect this cycle:
    - `inst` <= `if_rsp_data`, `pc` <= `req_addr`, `inst_ready` <= 1.
    - `fetch_pc` <= `req_addr` + 4; go to HOLD.
  - On `if_rsp_valid` with `discard` = 1 or `redirect_valid` = 1:
    - Drop the data; `discard` <= 0.
    - `req_addr` <= the effective `fetch_pc` (the redirect target if a redirect is present this cycle); go to REQ.
- HOLD:
  - `inst_ready` = 1; `inst` and `pc` are stable.
  - `redirect_valid` = 1 has priority over `id_ready`: `inst_ready` <= 0, `inst` <= INST_NOP, `fetch_pc` <= target, `req_addr` <= target, go to REQ.
  - Otherwise, if `id_ready` = 1: `inst_ready` <= 0, `req_addr` <= `fetch_pc`, go to REQ.
  - Otherwise stay in HOLD.
- Redirect while in REQ or WAIT (no usable response that cycle):
  - `fetch_pc` <= target; `discard` <= 1.
  - The bus transaction already started completes normally; its response is dropped.
  - A redirect in REQ does not change `if_req_addr` (stability rule).
- Redirect target: bits [1:0] forced to 0. A later redirect overwrites an earlier pending one.
- Arithmetic: 64-bit PC + 4 wraps modulo 2^64.
- Bus inputs: `if_rsp_valid` outside WAIT is ignored. `if_req_ready` outside REQ is ignored.
- Latency: request accepted in cycle N, response in N+k (k ≥ 1), `inst_ready` = 1 in cycle N+k+1.
- Throughput: back-to-back instructions no faster than 1 per 3 cycles.
- Reset mid-operation: at any state, the next cycle shows reset values and normal fetch restarts from PC_RESET.

Decomposition:
- PC_RESET default, INST_NOP and the state encodings belong in defines.v, alongside REG_BUS and ZERO_WORD.
- No sub-module: a single module containing the state machine and the PC register is natural.

Test Plan:
1. Release `rst`, `if_req_ready` = 1, response 0x00100093 one cycle after acceptance → `if_req_addr` = 0x8000_0000; `inst_ready` = 1, `inst` = 0x00100093, `pc` = 0x8000_0000 in the cycle after the response. Pulse `id_ready` → next `if_req_addr` = 0x8000_0004.
2. Hold `id_ready` = 0 for 5 cycles in HOLD → `inst` / `pc` unchanged, `inst_ready` = 1, `if_req_valid` = 0 throughout.
3. `if_req_ready` = 0 for 3 cycles with a redirect to 0x8000_0103 in cycle 2 → `if_req_addr` stays 0x8000_0000. The response for that request is dropped (`inst_ready` stays 0). Next request address = 0x8000_0100.
4. Redirect to 0x8000_0200 in the same cycle as `if_rsp_valid` → data dropped, `inst_ready` stays 0, next `if_req_addr` = 0x8000_0200.
5. In HOLD, `redirect_valid` and `id_ready` both 1, target 0x8000_0040 → `inst_ready` = 0, `inst` = 0x00000013 next cycle, next request address = 0x8000_0040.
6. Assert `rst` in WAIT and pulse `if_rsp_valid` during reset → next cycle all outputs at reset values, no `inst_ready`. After release, fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: bus widths, the
//   default reset fetch address, the bubble instruction, the fetch state
//   encoding and a small helper that word-aligns a redirect target.
//   No ports; imported by if_stage.
// ---------------------------------------------------------------------------
package if_stage_pkg;

  // Data path widths: 64-bit program counter, 32-bit instruction word
  localparam int REG_BUS  = 64;
  localparam int INST_BUS = 32;

  localparam logic [REG_BUS-1:0]  ZERO_WORD        = '0;
  localparam logic [REG_BUS-1:0]  PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  // addi x0,x0,0 is what decode sees whenever no instruction is presented
  localparam logic [INST_BUS-1:0] INST_NOP_DEFAULT = 32'h0000_0013;

  // Fetch sequencing: set up a request, present it, wait for data, hold data
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  // Instructions are 4-byte aligned, so the low two target bits are dropped
  function automatic logic [REG_BUS-1:0] align4(input logic [REG_BUS-1:0] addr);
    return {addr[REG_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage feeding decode. Keeps the architectural fetch PC,
//   issues one 32-bit fetch at a time over a valid/ready bus, holds each
//   fetched instruction until decode takes it, and follows redirects from
//   execute while throwing away responses that belong to the old path.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_req_valid/_ready/_addr   fetch request channel to instruction memory
//   if_rsp_valid/_ready/_data   fetch response channel from instruction memory
//   redirect_valid/_pc          redirect (branch/jal/jalr) from execute
//   id_ready          decode consumes the presented instruction this cycle
//   inst, inst_ready, pc        instruction, its valid flag and its PC
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [REG_BUS-1:0]  PC_RESET = PC_RESET_DEFAULT,
  parameter logic [INST_BUS-1:0] INST_NOP = INST_NOP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                if_req_valid,
  input  logic                if_req_ready,
  output logic [REG_BUS-1:0]  if_req_addr,
  input  logic                if_rsp_valid,
  output logic                if_rsp_ready,
  input  logic [INST_BUS-1:0] if_rsp_data,
  input  logic                redirect_valid,
  input  logic [REG_BUS-1:0]  redirect_pc,
  input  logic                id_ready,
  output logic [INST_BUS-1:0] inst,
  output logic                inst_ready,
  output logic [REG_BUS-1:0]  pc
);

  fetch_state_e        state_q;
  logic [REG_BUS-1:0]  fetchPc_q;
  logic [REG_BUS-1:0]  reqAddr_q;
  logic                discard_q;
  logic [INST_BUS-1:0] inst_q;
  logic [REG_BUS-1:0]  pc_q;
  logic [REG_BUS-1:0]  redirTarget;

  assign redirTarget = align4(redirect_pc);

  // Every output is either a register or a pure decode of the state register,
  // so nothing on the input side can ripple straight through to an output.
  assign if_req_valid = (state_q == ST_REQ);
  assign if_rsp_ready = (state_q == ST_WAIT);
  assign inst_ready   = (state_q == ST_HOLD);
  assign if_req_addr  = reqAddr_q;
  assign inst         = inst_q;
  assign pc           = pc_q;

  // Fetch state machine together with the PC, request address and the
  // discard flag. discard marks the in-flight transaction as belonging to a
  // path that a redirect has abandoned: the bus transaction is still allowed
  // to finish, but its data is dropped and fetch restarts at fetchPc_q.
  // inst_q falls back to the bubble whenever the held instruction leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fetchPc_q <= PC_RESET;
      reqAddr_q <= PC_RESET;
      discard_q <= 1'b0;
      inst_q    <= INST_NOP;
      pc_q      <= ZERO_WORD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          if (redirect_valid) begin
            fetchPc_q <= redirTarget;
            reqAddr_q <= redirTarget;
          end else begin
            reqAddr_q <= fetchPc_q;
          end
        end

        // The presented address must stay put until accepted, so a redirect
        // here only retargets fetchPc_q and poisons the pending response.
        ST_REQ: begin
          if (redirect_valid) begin
            fetchPc_q <= redirTarget;
            discard_q <= 1'b1;
          end
          if (if_req_ready) begin
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (if_rsp_valid) begin
            if (discard_q || redirect_valid) begin
              discard_q <= 1'b0;
              state_q   <= ST_REQ;
              if (redirect_valid) begin
                fetchPc_q <= redirTarget;
                reqAddr_q <= redirTarget;
              end else begin
                reqAddr_q <= fetchPc_q;
              end
            end else begin
              inst_q    <= if_rsp_data;
              pc_q      <= reqAddr_q;
              fetchPc_q <= reqAddr_q + 64'd4;
              state_q   <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            fetchPc_q <= redirTarget;
            discard_q <= 1'b1;
          end
        end

        // A redirect squashes the held instruction even if decode is taking
        // it in the same cycle.
        ST_HOLD: begin
          if (redirect_valid) begin
            inst_q    <= INST_NOP;
            fetchPc_q <= redirTarget;
            reqAddr_q <= redirTarget;
            state_q   <= ST_REQ;
          end else if (id_ready) begin
            inst_q    <= INST_NOP;
            reqAddr_q <= fetchPc_q;
            state_q   <= ST_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage: directed fetch/redirect/reset
//   sequences, a table of redirect targets (alignment and PC wrap), and a
//   randomized run against a transaction-level model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic [31:0] inst;
  logic        inst_ready;
  logic [63:0] pc;

  int compared   = 0;
  int mismatched = 0;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_ready   (if_rsp_ready),
    .if_rsp_data    (if_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst           (inst),
    .inst_ready     (inst_ready),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] target;
    logic [63:0] expReq;
    logic [31:0] data;
    logic [63:0] expNext;
  } vec_t;

  vec_t vecs [4];

  // Contents of the pretend instruction memory, derived from the address
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  // Drive all inputs for one cycle, then move to the next sampling point
  task automatic applyStimulus(input logic r, input logic rqRdy, input logic rsV,
                               input logic [31:0] rsD, input logic rdV,
                               input logic [63:0] rdPc, input logic idR);
    rst            = r;
    if_req_ready   = rqRdy;
    if_rsp_valid   = rsV;
    if_rsp_data    = rsD;
    redirect_valid = rdV;
    redirect_pc    = rdPc;
    id_ready       = idR;
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " req_valid"}, {63'd0, if_req_valid}, 64'd0);
    checkOutput({tag, " rsp_ready"}, {63'd0, if_rsp_ready}, 64'd0);
    checkOutput({tag, " inst_ready"}, {63'd0, inst_ready}, 64'd0);
    checkOutput({tag, " inst"}, {32'd0, inst}, {32'd0, NOP});
    checkOutput({tag, " pc"}, pc, 64'd0);
    checkOutput({tag, " req_addr"}, if_req_addr, PC_RST);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 1'b0);
    checkResetValues("reset");
    rst = 1'b0;
  endtask

  // Randomized-run model state: the fetch stream seen as transactions
  bit          mHold, mInReq, mOut, mStale, mReqNext, idle;
  logic [63:0] mNext, mReqAddr, mCurAddr, mHoldPc, tgt;
  logic [31:0] mHoldInst;
  int          mDelay, deliveries;

  initial begin
    vecs[0] = '{64'h0000_0000_8000_0103, 64'h0000_0000_8000_0100, 32'h0020_0113, 64'h0000_0000_8000_0104};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193, 64'h0000_0000_0000_0000};
    vecs[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 32'h0040_0213, 64'h0000_0000_0000_0004};
    vecs[3] = '{64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEF4, 32'h0050_0293, 64'h1234_5678_9ABC_DEF8};

    // Basic fetch from reset, then consume
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t1 req_valid", {63'd0, if_req_valid}, 64'd1);
    checkOutput("t1 req_addr", if_req_addr, PC_RST);
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t1 rsp_ready", {63'd0, if_rsp_ready}, 64'd1);
    checkOutput("t1 inst_ready early", {63'd0, inst_ready}, 64'd0);
    applyStimulus(0, 0, 1, 32'h0010_0093, 0, 64'd0, 0);
    checkOutput("t1 inst_ready", {63'd0, inst_ready}, 64'd1);
    checkOutput("t1 inst", {32'd0, inst}, 64'h0010_0093);
    checkOutput("t1 pc", pc, PC_RST);
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 1);
    checkOutput("t1 next req_addr", if_req_addr, 64'h8000_0004);
    checkOutput("t1 next req_valid", {63'd0, if_req_valid}, 64'd1);
    checkOutput("t1 inst_ready cleared", {63'd0, inst_ready}, 64'd0);

    // Decode stalls: held instruction stays put, no new request
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 0, 1, 32'h0020_0113, 0, 64'd0, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2 inst_ready", {63'd0, inst_ready}, 64'd1);
      checkOutput("t2 inst", {32'd0, inst}, 64'h0020_0113);
      checkOutput("t2 pc", pc, 64'h8000_0004);
      checkOutput("t2 req_valid", {63'd0, if_req_valid}, 64'd0);
      applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    end

    // Redirect while the request is stalled on the bus
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t3 addr c1", if_req_addr, PC_RST);
    applyStimulus(0, 0, 0, 32'd0, 1, 64'h8000_0103, 0);
    checkOutput("t3 addr c2", if_req_addr, PC_RST);
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t3 addr c3", if_req_addr, PC_RST);
    checkOutput("t3 valid c3", {63'd0, if_req_valid}, 64'd1);
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0, 64'd0, 0);
    checkOutput("t3 dropped inst_ready", {63'd0, inst_ready}, 64'd0);
    checkOutput("t3 next req_valid", {63'd0, if_req_valid}, 64'd1);
    checkOutput("t3 next req_addr", if_req_addr, 64'h8000_0100);

    // Redirect in the same cycle as the response
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 0, 1, 32'h1111_2222, 1, 64'h8000_0200, 0);
    checkOutput("t4 inst_ready", {63'd0, inst_ready}, 64'd0);
    checkOutput("t4 req_addr", if_req_addr, 64'h8000_0200);
    checkOutput("t4 req_valid", {63'd0, if_req_valid}, 64'd1);

    // Redirect beats id_ready in HOLD
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 0, 1, 32'h0060_0313, 0, 64'd0, 0);
    checkOutput("t5 pc", pc, 64'h8000_0200);
    applyStimulus(0, 0, 0, 32'd0, 1, 64'h8000_0040, 1);
    checkOutput("t5 inst_ready", {63'd0, inst_ready}, 64'd0);
    checkOutput("t5 inst", {32'd0, inst}, {32'd0, NOP});
    checkOutput("t5 req_addr", if_req_addr, 64'h8000_0040);

    // Reset while waiting, with a response arriving during reset
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t6 rsp_ready", {63'd0, if_rsp_ready}, 64'd1);
    applyStimulus(1, 0, 1, 32'h0070_0393, 0, 64'd0, 0);
    checkResetValues("t6");
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    checkOutput("t6 restart valid", {63'd0, if_req_valid}, 64'd1);
    checkOutput("t6 restart addr", if_req_addr, PC_RST);
    checkOutput("t6 inst_ready", {63'd0, inst_ready}, 64'd0);

    // Table of redirect targets: alignment and 64-bit wrap of PC+4
    doReset();
    applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
    applyStimulus(0, 0, 1, 32'h0000_0013, 0, 64'd0, 0);
    for (int v = 0; v < 4; v++) begin
      applyStimulus(0, 0, 0, 32'd0, 1, vecs[v].target, 0);
      checkOutput("tbl req_addr", if_req_addr, vecs[v].expReq);
      applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
      applyStimulus(0, 0, 1, vecs[v].data, 0, 64'd0, 0);
      checkOutput("tbl inst", {32'd0, inst}, {32'd0, vecs[v].data});
      checkOutput("tbl pc", pc, vecs[v].expReq);
      applyStimulus(0, 0, 0, 32'd0, 0, 64'd0, 1);
      checkOutput("tbl next addr", if_req_addr, vecs[v].expNext);
      applyStimulus(0, 1, 0, 32'd0, 0, 64'd0, 0);
      applyStimulus(0, 0, 1, 32'h0000_0013, 0, 64'd0, 0);
    end

    // Randomized run against the transaction-level model
    doReset();
    mHold = 0; mInReq = 0; mOut = 0; mStale = 0; mReqNext = 0;
    mNext = PC_RST; mReqAddr = '0; mCurAddr = '0; mHoldPc = '0; mHoldInst = NOP;
    mDelay = 0; deliveries = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      checkOutput("rnd inst_ready", {63'd0, inst_ready}, {63'd0, mHold});
      if (mHold) begin
        checkOutput("rnd inst", {32'd0, inst}, {32'd0, mHoldInst});
        checkOutput("rnd pc", pc, mHoldPc);
      end else begin
        checkOutput("rnd inst bubble", {32'd0, inst}, {32'd0, NOP});
      end
      if (mReqNext) begin
        checkOutput("rnd req_valid new", {63'd0, if_req_valid}, 64'd1);
        checkOutput("rnd req_addr new", if_req_addr, mReqAddr);
        mInReq = 1; mCurAddr = mReqAddr; mReqNext = 0;
      end else if (mInReq) begin
        checkOutput("rnd req_valid held", {63'd0, if_req_valid}, 64'd1);
        checkOutput("rnd req_addr held", if_req_addr, mCurAddr);
      end else begin
        checkOutput("rnd req_valid idle", {63'd0, if_req_valid}, 64'd0);
      end
      checkOutput("rnd rsp_ready", {63'd0, if_rsp_ready}, {63'd0, mOut});

      idle         = !mHold && !mInReq && !mOut;
      if_req_ready = ($urandom_range(0, 9) < 7);
      if (mOut) begin
        if (mDelay == 0) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = memWord(mCurAddr);
        end else begin
          if_rsp_valid = 1'b0;
          if_rsp_data  = $urandom;
          mDelay--;
        end
      end else begin
        if_rsp_valid = ($urandom_range(0, 3) == 0);
        if_rsp_data  = $urandom;
      end
      redirect_valid = !idle && ($urandom_range(0, 11) == 0);
      redirect_pc    = {32'd0, 16'h8000, 16'($urandom)};
      id_ready       = ($urandom_range(0, 2) == 0);

      tgt = {redirect_pc[63:2], 2'b00};
      if (mHold) begin
        if (redirect_valid) begin
          mHold = 0; mNext = tgt; mReqNext = 1; mReqAddr = tgt;
        end else if (id_ready) begin
          mHold = 0; mReqNext = 1; mReqAddr = mNext;
        end
      end else if (mInReq) begin
        if (redirect_valid) begin
          mNext = tgt; mStale = 1;
        end
        if (if_req_ready) begin
          mInReq = 0; mOut = 1; mDelay = $urandom_range(0, 2);
        end
      end else if (mOut) begin
        if (if_rsp_valid) begin
          mOut = 0;
          if (mStale || redirect_valid) begin
            mStale = 0;
            if (redirect_valid) mNext = tgt;
            mReqNext = 1; mReqAddr = mNext;
          end else begin
            mHold = 1; mHoldInst = memWord(mCurAddr); mHoldPc = mCurAddr;
            mNext = mCurAddr + 64'd4; deliveries++;
          end
        end else if (redirect_valid) begin
          mNext = tgt; mStale = 1;
        end
      end else begin
        mReqNext = 1; mReqAddr = mNext;
      end
      @(negedge clk);
    end
    checkOutput("rnd progress", {63'd0, deliveries >= 20}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
